x_bus_arb2: RTL and testbench
=============================

# x_bus_arb2

Two-master arbiter that shares the single memory port of the rv32i core's valid/accept bus between the core (master 0) and a second bus master such as a program loader or DMA (master 1). It holds a grant for one whole transaction, alternates priority round-robin, and bounds every transaction with a timeout counter. The slave side connects directly to the memory or peripheral fabric and uses the same protocol as the core's own port.

## Interface
- TIMEOUT, 255: BUSY cycles without slave accept before forced completion; 0 disables the timeout.
- ERR_DATA, 32'hDEAD_BEEF: read data returned to a master on timeout.
- i_clk  in  1  single clock, rising edge.
- i_nrst  in  1  reset, asynchronous, active-low.
- i_m0_valid / i_m1_valid  in  1  master request; held with its fields stable until accepted.
- i_m0_rnw / i_m1_rnw  in  1  1 = read, 0 = write.
- i_m0_addr / i_m1_addr  in  32  byte address.
- i_m0_data / i_m1_data  in  32  write data.
- o_m0_accept / o_m1_accept  out  1  transaction complete; read data valid this cycle.
- o_m0_data / o_m1_data  out  32  read data.
- o_s_valid  out  1  slave request.
- o_s_rnw  out  1  forwarded from the granted master.
- o_s_addr  out  32  forwarded from the granted master.
- o_s_data  out  32  forwarded from the granted master.
- i_s_accept  in  1  slave completion.
- i_s_data  in  32  slave read data, valid when i_s_accept is high.
- o_timeout  out  1  sticky flag: a timeout has occurred.
- i_timeout_clr  in  1  clears o_timeout.

## Operation
- State machine states: IDLE and BUSY. Registers: state_q, gnt_q (0/1), prio_q (0/1), cnt_q (width $clog2(TIMEOUT+1), minimum 1), to_q.
- IDLE: if any valid is high, load gnt_q and go to BUSY. Grant selection:
  - only one master valid: grant that master;
  - both valid: grant prio_q.
  - cnt_q is cleared in this transition.
- BUSY, combinational forwarding:
  - o_s_valid = granted master's valid; o_s_rnw, o_s_addr and o_s_data follow the granted master.
  - o_mX_accept = i_s_accept, for X = gnt_q only.
  - o_mX_data = i_s_data for the granted master; 0 for the non-granted master.
- BUSY completion on i_s_accept: return to IDLE and set prio_q = ~gnt_q.
- Timeout: in BUSY without accept, cnt_q increments.
  - When TIMEOUT != 0 and cnt_q == TIMEOUT-1 with no accept in the same cycle, force completion: o_mX_accept = 1, o_mX_data = ERR_DATA, to_q set, return to IDLE, prio_q = ~gnt_q.
  - A slave accept in that same cycle takes precedence: normal completion, no flag.
- Abort: if the granted master drops valid while BUSY (protocol violation), return to IDLE with no accept. prio_q is unchanged and o_s_valid is low in that cycle.
- o_timeout = to_q. i_timeout_clr clears it. If a set and a clear occur in the same cycle, the set wins.
- Non-granted master: its accept is 0 and its request waits. There is no combinational path from one master's inputs to the other master's outputs.
- Reset mid-transaction: everything returns to reset values immediately. An outstanding slave transaction is dropped (o_s_valid goes low).

## Timing
- Reset values:
  - state_q = IDLE, gnt_q = 0, prio_q = 0 (master 0 preferred), cnt_q = 0, to_q = 0.
  - Resulting outputs: o_s_valid, o_s_rnw, both accepts and o_timeout are 0; o_s_addr, o_s_data and both o_mX_data are 0.
- Arbitration latency is one cycle. A request at cycle N appears on o_s_valid at N+1, so the earliest accept is at N+1.
- Back-to-back transactions: after an accept at cycle N, state is IDLE at N+1 and the next grant appears on o_s_valid at N+2. There is one bubble cycle per transaction.
- Timeout fires in the TIMEOUT-th BUSY cycle: the grant at N+1 leads to a forced accept at N+TIMEOUT.
- In IDLE, the o_s_* outputs are 0 and no accept is driven.
- Under continuous requests from both masters, grants strictly alternate; neither master waits more than one transaction.

## Test plan
- Single master: m0 read of 0x100 and slave accept with 0x12345678 two cycles after o_s_valid -> o_s_valid at N+1; o_m0_accept and o_m0_data = 0x12345678 on the accept cycle; o_m1_accept stays 0.
- Contention: both valid at cycle 1 after reset -> m0 granted first; after its accept, m1 is granted (o_s_addr = m1 addr); a repeat shows the order m0, m1, m0, m1.
- Write forwarding: m1 write of 0xCAFEF00D to 0x2000 -> o_s_rnw = 0, o_s_addr = 0x2000, o_s_data = 0xCAFEF00D, held stable until i_s_accept.
- Timeout with TIMEOUT = 4 and the slave never accepting -> o_m0_accept with 0xDEADBEEF in the 4th BUSY cycle; o_timeout = 1 until i_timeout_clr; a collision where i_s_accept arrives in the 4th cycle returns slave data and does not set the flag.
- Abort: the granted master drops valid mid-BUSY -> IDLE next cycle, no accept, prio_q unchanged.
- Reset asserted during BUSY -> all outputs are 0 asynchronously; after release, the first grant goes to m0.

Source files
------------

// File: rtl/x_bus_arb2.sv
// Two-master arbiter for the rv32i valid/accept memory bus: whole-transaction grants,
// round-robin priority, and a per-transaction timeout that completes with ERR_DATA.
module x_bus_arb2 #(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic        i_clk,
   input  logic        i_nrst,
   input  logic        i_m0_valid,
   input  logic        i_m0_rnw,
   input  logic [31:0] i_m0_addr,
   input  logic [31:0] i_m0_data,
   output logic        o_m0_accept,
   output logic [31:0] o_m0_data,
   input  logic        i_m1_valid,
   input  logic        i_m1_rnw,
   input  logic [31:0] i_m1_addr,
   input  logic [31:0] i_m1_data,
   output logic        o_m1_accept,
   output logic [31:0] o_m1_data,
   output logic        o_s_valid,
   output logic        o_s_rnw,
   output logic [31:0] o_s_addr,
   output logic [31:0] o_s_data,
   input  logic        i_s_accept,
   input  logic [31:0] i_s_data,
   output logic        o_timeout,
   input  logic        i_timeout_clr,
   output logic [2:0]  o_dbg_state
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
   localparam logic TO_EN = (TIMEOUT != 0);

   // Valid/accept handshake: a master holds valid with stable fields until its accept
   // pulses for one cycle; accept means the transaction is complete and read data is valid.

   logic [0:0]    state_q, state_d;
   logic          gnt_q, gnt_d;
   logic          prio_q, prio_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          to_q, to_d;

   logic busy;
   logic m0_sel, m1_sel;
   logic m0_live, m1_live;
   logic to_fire;
   logic to_set;

   always_comb begin
      busy    = (state_q == ST_BUSY);
      m0_sel  = busy & ~gnt_q;
      m1_sel  = busy & gnt_q;
      m0_live = m0_sel & i_m0_valid;
      m1_live = m1_sel & i_m1_valid;
      to_fire = TO_EN & (cnt_q == CNT_LAST) & ~i_s_accept;
      to_set  = (m0_live | m1_live) & to_fire;
   end

   // Per-master paths are kept separate so nothing of one master reaches the other's outputs.
   always_comb begin
      o_s_valid = m0_live | m1_live;
      o_s_rnw   = (m0_sel & i_m0_rnw) | (m1_sel & i_m1_rnw);
      o_s_addr  = m0_sel ? i_m0_addr : (m1_sel ? i_m1_addr : 32'h0);
      o_s_data  = m0_sel ? i_m0_data : (m1_sel ? i_m1_data : 32'h0);

      o_m0_accept = m0_live & (i_s_accept | to_fire);
      o_m1_accept = m1_live & (i_s_accept | to_fire);
      o_m0_data   = m0_sel ? ((m0_live & to_fire) ? ERR_DATA : i_s_data) : 32'h0;
      o_m1_data   = m1_sel ? ((m1_live & to_fire) ? ERR_DATA : i_s_data) : 32'h0;

      o_timeout   = to_q;
      o_dbg_state = {prio_q, gnt_q, state_q};
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      prio_d  = prio_q;
      cnt_d   = cnt_q;
      to_d    = (to_q & ~i_timeout_clr) | to_set;

      case (state_q)
         ST_IDLE: begin
            if (i_m0_valid | i_m1_valid) begin
               gnt_d   = (i_m0_valid & i_m1_valid) ? prio_q : i_m1_valid;
               state_d = ST_BUSY;
               cnt_d   = '0;
            end
         end
         default: begin
            if (!(m0_live | m1_live)) begin
               // Granted master withdrew its request: drop it without completing.
               state_d = ST_IDLE;
            end else if (i_s_accept | to_fire) begin
               state_d = ST_IDLE;
               prio_d  = ~gnt_q;
            end else begin
               cnt_d = cnt_q + CW'(1'b1);
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state_q <= ST_IDLE;
         gnt_q   <= 1'b0;
         prio_q  <= 1'b0;
         cnt_q   <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         prio_q  <= prio_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
      end
   end

endmodule

// File: tb/tb_x_bus_arb2.sv
// Directed bench for x_bus_arb2 (TIMEOUT = 4): per-cycle vector table plus an
// asynchronous-reset sequence.
module tb_x_bus_arb2;

   localparam logic [31:0] M0_ADDR  = 32'h0000_0100;
   localparam logic [31:0] M0_WDATA = 32'h0BAD_0000;
   localparam logic [31:0] M1_ADDR  = 32'h0000_2000;
   localparam logic [31:0] M1_WDATA = 32'hCAFE_F00D;
   localparam logic [31:0] ERR      = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_valid, m0_rnw, m1_valid, m1_rnw;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_accept, m1_accept;
   logic [31:0] m0_rdata, m1_rdata;
   logic        s_valid, s_rnw, s_accept;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic        timeout, timeout_clr;
   logic [2:0]  dbg_state;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   x_bus_arb2 #(.TIMEOUT(4), .ERR_DATA(32'hDEAD_BEEF)) dut (
      .i_clk(clk), .i_nrst(rst_n),
      .i_m0_valid(m0_valid), .i_m0_rnw(m0_rnw), .i_m0_addr(m0_addr), .i_m0_data(m0_wdata),
      .o_m0_accept(m0_accept), .o_m0_data(m0_rdata),
      .i_m1_valid(m1_valid), .i_m1_rnw(m1_rnw), .i_m1_addr(m1_addr), .i_m1_data(m1_wdata),
      .o_m1_accept(m1_accept), .o_m1_data(m1_rdata),
      .o_s_valid(s_valid), .o_s_rnw(s_rnw), .o_s_addr(s_addr), .o_s_data(s_wdata),
      .i_s_accept(s_accept), .i_s_data(s_rdata),
      .o_timeout(timeout), .i_timeout_clr(timeout_clr),
      .o_dbg_state(dbg_state)
   );

   // g: 0 = idle (slave side all zero), 1 = m0 granted, 2 = m1 granted
   typedef struct {
      logic        m0v, m1v, acc, clr;
      logic [31:0] rdata;
      logic [1:0]  g;
      logic        sv, eacc;
      logic [31:0] erd;
      logic        eto;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic m0v, input logic m1v, input logic acc,
                               input logic [31:0] rdata, input logic clr, input logic [1:0] g,
                               input logic sv, input logic eacc, input logic [31:0] erd,
                               input logic eto);
      vec_t v;
      v.m0v = m0v; v.m1v = m1v; v.acc = acc; v.rdata = rdata; v.clr = clr;
      v.g = g; v.sv = sv; v.eacc = eacc; v.erd = erd; v.eto = eto;
      return v;
   endfunction

   task automatic check(input string name, input int row, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
      end
   endtask

   task automatic run_vec(input int row, input vec_t v);
      logic [31:0] e_addr, e_wdata, e_m0d, e_m1d;
      logic        e_rnw, e_m0a, e_m1a;
      @(posedge clk);
      #1;
      m0_valid = v.m0v; m1_valid = v.m1v;
      s_accept = v.acc; s_rdata = v.rdata; timeout_clr = v.clr;
      #3;
      e_rnw   = (v.g == 2'd1);
      e_addr  = (v.g == 2'd1) ? M0_ADDR  : ((v.g == 2'd2) ? M1_ADDR  : 32'h0);
      e_wdata = (v.g == 2'd1) ? M0_WDATA : ((v.g == 2'd2) ? M1_WDATA : 32'h0);
      e_m0a   = (v.g == 2'd1) & v.eacc;
      e_m1a   = (v.g == 2'd2) & v.eacc;
      e_m0d   = (v.g == 2'd1) ? v.erd : 32'h0;
      e_m1d   = (v.g == 2'd2) ? v.erd : 32'h0;
      check("s_valid",   row, {31'h0, s_valid},   {31'h0, v.sv});
      check("s_rnw",     row, {31'h0, s_rnw},     {31'h0, e_rnw});
      check("s_addr",    row, s_addr,             e_addr);
      check("s_wdata",   row, s_wdata,            e_wdata);
      check("m0_accept", row, {31'h0, m0_accept}, {31'h0, e_m0a});
      check("m0_data",   row, m0_rdata,           e_m0d);
      check("m1_accept", row, {31'h0, m1_accept}, {31'h0, e_m1a});
      check("m1_data",   row, m1_rdata,           e_m1d);
      check("timeout",   row, {31'h0, timeout},   {31'h0, v.eto});
   endtask

   initial begin
      rst_n = 1'b0;
      m0_valid = 1'b0; m0_rnw = 1'b1; m0_addr = M0_ADDR; m0_wdata = M0_WDATA;
      m1_valid = 1'b0; m1_rnw = 1'b0; m1_addr = M1_ADDR; m1_wdata = M1_WDATA;
      s_accept = 1'b0; s_rdata = 32'h0; timeout_clr = 1'b0;

      // contention from reset: m0, m1, m0, m1
      tbl.push_back(mk(0,0,0,32'h0,0, 0,0,0,32'h0,0));
      tbl.push_back(mk(1,1,0,32'h0,0, 0,0,0,32'h0,0));
      tbl.push_back(mk(1,1,0,32'h0,0, 1,1,0,32'h0,0));
      tbl.push_back(mk(1,1,1,32'h1111_1111,0, 1,1,1,32'h1111_1111,0));
      tbl.push_back(mk(1,1,0,32'h0,0, 0,0,0,32'h0,0));
      tbl.push_back(mk(1,1,1,32'h2222_2222,0, 2,1,1,32'h2222_2222,0));
      tbl.push_back(mk(1,1,0,32'h0,0, 0,0,0,32'h0,0));
      tbl.push_back(mk(1,1,1,32'h3333_3333,0, 1,1,1,32'h3333_3333,0));
      tbl.push_back(mk(1,1,0,32'h0,0, 0,0,0,32'h0,0));
      // m1 write held stable until accept
      tbl.push_back(mk(1,1,0,32'h0,0, 2,1,0,32'h0,0));
      tbl.push_back(mk(0,1,0,32'h0,0, 2,1,0,32'h0,0));
      tbl.push_back(mk(0,1,1,32'h4444_4444,0, 2,1,1,32'h4444_4444,0));
      // single m0 read, accept two cycles after s_valid
      tbl.push_back(mk(1,0,0,32'h0,0, 0,0,0,32'h0,0));
      tbl.push_back(mk(1,0,0,32'h0,0, 1,1,0,32'h0,0));
      tbl.push_back(mk(1,0,0,32'h0,0, 1,1,0,32'h0,0));
      tbl.push_back(mk(1,0,1,32'h1234_5678,0, 1,1,1,32'h1234_5678,0));
      tbl.push_back(mk(0,0,0,32'h0,0, 0,0,0,32'h0,0));
      // timeout in the 4th BUSY cycle, sticky flag, clear
      tbl.push_back(mk(1,0,0,32'h0,0, 0,0,0,32'h0,0));
      tbl.push_back(mk(1,0,0,32'h0,0, 1,1,0,32'h0,0));
      tbl.push_back(mk(1,0,0,32'h0,0, 1,1,0,32'h0,0));
      tbl.push_back(mk(1,0,0,32'h0,0, 1,1,0,32'h0,0));
      tbl.push_back(mk(1,0,0,32'h0,0, 1,1,1,ERR,0));
      tbl.push_back(mk(0,0,0,32'h0,0, 0,0,0,32'h0,1));
      tbl.push_back(mk(0,0,0,32'h0,1, 0,0,0,32'h0,1));
      tbl.push_back(mk(0,0,0,32'h0,0, 0,0,0,32'h0,0));
      // accept collides with the timeout cycle: slave data, no flag
      tbl.push_back(mk(1,0,0,32'h0,0, 0,0,0,32'h0,0));
      tbl.push_back(mk(1,0,0,32'h0,0, 1,1,0,32'h0,0));
      tbl.push_back(mk(1,0,0,32'h0,0, 1,1,0,32'h0,0));
      tbl.push_back(mk(1,0,0,32'h0,0, 1,1,0,32'h0,0));
      tbl.push_back(mk(1,0,1,32'h55AA_55AA,0, 1,1,1,32'h55AA_55AA,0));
      tbl.push_back(mk(0,0,0,32'h0,0, 0,0,0,32'h0,0));
      // abort by m1; priority stays with m1
      tbl.push_back(mk(0,1,0,32'h0,0, 0,0,0,32'h0,0));
      tbl.push_back(mk(0,1,0,32'h0,0, 2,1,0,32'h0,0));
      tbl.push_back(mk(0,0,0,32'h0,0, 2,0,0,32'h0,0));
      tbl.push_back(mk(1,1,0,32'h0,0, 0,0,0,32'h0,0));
      tbl.push_back(mk(1,1,1,32'h6666_6666,0, 2,1,1,32'h6666_6666,0));
      tbl.push_back(mk(0,0,0,32'h0,0, 0,0,0,32'h0,0));
      // timeout set coincides with clear: set wins
      tbl.push_back(mk(1,0,0,32'h0,0, 0,0,0,32'h0,0));
      tbl.push_back(mk(1,0,0,32'h0,0, 1,1,0,32'h0,0));
      tbl.push_back(mk(1,0,0,32'h0,0, 1,1,0,32'h0,0));
      tbl.push_back(mk(1,0,0,32'h0,0, 1,1,0,32'h0,0));
      tbl.push_back(mk(1,0,0,32'h0,1, 1,1,1,ERR,0));
      tbl.push_back(mk(0,0,0,32'h0,0, 0,0,0,32'h0,1));
      tbl.push_back(mk(0,0,0,32'h0,1, 0,0,0,32'h0,1));
      tbl.push_back(mk(0,0,0,32'h0,0, 0,0,0,32'h0,0));

      // outputs while held in reset
      repeat (2) @(posedge clk);
      #4;
      check("rst_s_valid", -1, {31'h0, s_valid}, 32'h0);
      check("rst_dbg",     -1, {29'h0, dbg_state}, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      foreach (tbl[i]) run_vec(i, tbl[i]);

      // asynchronous reset in the middle of an m1 transaction (priority is m1 here)
      @(posedge clk);
      #1 m1_valid = 1'b1; m0_valid = 1'b0; s_accept = 1'b0; timeout_clr = 1'b0;
      @(posedge clk);
      #2;
      check("pre_rst_s_addr", 100, s_addr, M1_ADDR);
      check("pre_rst_dbg",    100, {29'h0, dbg_state}, 32'h7);
      rst_n = 1'b0;
      #1;
      check("arst_s_valid", 101, {31'h0, s_valid},   32'h0);
      check("arst_s_addr",  101, s_addr,             32'h0);
      check("arst_s_wdata", 101, s_wdata,            32'h0);
      check("arst_m1_acc",  101, {31'h0, m1_accept}, 32'h0);
      check("arst_m1_data", 101, m1_rdata,           32'h0);
      check("arst_dbg",     101, {29'h0, dbg_state}, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1; m0_valid = 1'b1; m1_valid = 1'b1;
      @(posedge clk);
      #3;
      check("post_rst_s_valid", 102, {31'h0, s_valid}, 32'h1);
      check("post_rst_s_addr",  102, s_addr,           M0_ADDR);
      m0_valid = 1'b0; m1_valid = 1'b0;
      repeat (2) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
